// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter / instruction-fetch sequencer.
package pc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_REQ,
        ST_HOLD
    } fetch_state_e;

    // Where the next pc comes from when it is updated.
    typedef enum logic [1:0] {
        SRC_SEQ,
        SRC_BRANCH,
        SRC_FLUSH,
        SRC_REDIR
    } redir_src_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'hbfc00000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'hbfc00380;

endpackage

// File: rtl/pc_redirect_buf.sv
// Buffers branch and exception/ERET redirects against the in-flight fetch and
// selects the source of the next pc.
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = DEF_EXC_VECTOR[ADDR_W-1:0]
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_req,
    input  logic              ack_taken,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_valid,
    input  logic              eret_valid,
    input  logic [ADDR_W-1:0] epc,
    output logic              upd_vld,
    output redir_src_e        upd_src,
    output logic [ADDR_W-1:0] upd_target,
    output logic              discard,
    output logic              delay_slot
);

    logic              br_pend_q, br_pend_d;
    logic [ADDR_W-1:0] br_tgt_q, br_tgt_d;
    logic              fl_pend_q, fl_pend_d;
    logic [ADDR_W-1:0] fl_tgt_q, fl_tgt_d;
    logic              redir;
    logic [ADDR_W-1:0] redir_tgt;

    assign redir     = exc_valid | eret_valid;
    assign redir_tgt = exc_valid ? EXC_VECTOR : epc;

    always_comb begin
        br_pend_d  = br_pend_q;
        br_tgt_d   = br_tgt_q;
        fl_pend_d  = fl_pend_q;
        fl_tgt_d   = fl_tgt_q;
        upd_vld    = ack_taken | (redir & ~in_req);
        upd_src    = SRC_SEQ;
        upd_target = '0;
        discard    = ack_taken & (redir | fl_pend_q);
        delay_slot = ack_taken & ~discard & br_pend_q;

        if (redir) begin
            upd_src    = SRC_REDIR;
            upd_target = redir_tgt;
        end else if (fl_pend_q) begin
            upd_src    = SRC_FLUSH;
            upd_target = fl_tgt_q;
        end else if (br_pend_q) begin
            upd_src    = SRC_BRANCH;
            upd_target = br_tgt_q;
        end

        // Any completed fetch consumes both pending redirects.
        if (ack_taken) begin
            fl_pend_d = 1'b0;
            br_pend_d = 1'b0;
        end

        if (redir) begin
            br_pend_d = 1'b0;
            if (in_req && !ack_taken) begin
                fl_pend_d = 1'b1;
                fl_tgt_d  = redir_tgt;
            end
        end else if (br_valid && !discard) begin
            br_pend_d = 1'b1;
            br_tgt_d  = br_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_pend_q <= 1'b0;
            br_tgt_q  <= '0;
            fl_pend_q <= 1'b0;
            fl_tgt_q  <= '0;
        end else begin
            br_pend_q <= br_pend_d;
            br_tgt_q  <= br_tgt_d;
            fl_pend_q <= fl_pend_d;
            fl_tgt_q  <= fl_tgt_d;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding fetch sequencer; pc advances on the
// edge that samples fetch_ack, redirects come from pc_redirect_buf.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR[ADDR_W-1:0],
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = DEF_EXC_VECTOR[ADDR_W-1:0],
    parameter int                STEP         = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_valid,
    input  logic              eret_valid,
    input  logic [ADDR_W-1:0] epc,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              inst_valid,
    output logic              inst_ds
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              in_req;
    logic              ack_taken;
    logic              upd_vld;
    redir_src_e        upd_src;
    logic [ADDR_W-1:0] upd_target;
    logic              discard;
    logic              delay_slot;

    assign in_req    = (state_q == ST_REQ);
    assign ack_taken = fetch_ack & in_req;

    pc_redirect_buf #(
        .ADDR_W     (ADDR_W),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_redirect_buf (
        .clk        (clk),
        .reset      (reset),
        .in_req     (in_req),
        .ack_taken  (ack_taken),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .exc_valid  (exc_valid),
        .eret_valid (eret_valid),
        .epc        (epc),
        .upd_vld    (upd_vld),
        .upd_src    (upd_src),
        .upd_target (upd_target),
        .discard    (discard),
        .delay_slot (delay_slot)
    );

    always_comb begin
        state_d    = state_q;
        fetch_req  = 1'b0;
        inst_valid = 1'b0;
        inst_ds    = 1'b0;
        case (state_q)
            ST_BOOT: state_d = stall ? ST_HOLD : ST_REQ;
            ST_REQ: begin
                fetch_req  = 1'b1;
                inst_valid = ack_taken & ~discard;
                inst_ds    = delay_slot;
                if (fetch_ack) state_d = stall ? ST_HOLD : ST_REQ;
            end
            ST_HOLD: if (!stall) state_d = ST_REQ;
            default: state_d = ST_BOOT;
        endcase
    end

    // Sequential addition wraps silently at 2^ADDR_W.
    always_comb begin
        pc_d = pc_q;
        if (upd_vld) pc_d = (upd_src == SRC_SEQ) ? pc_q + ADDR_W'(STEP) : upd_target;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign fetch_addr = pc_q;
    assign pc         = pc_q;

endmodule
